// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch read-only, load/store read/write) in front of a single-port memory.
// Optional build macro MEM_ARB_RR_EN: round-robin on simultaneous requests instead of data-over-fetch priority.
module mem_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ack,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ack,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_w,
    output logic                  mem_r,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        ACK    = 2'd3
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_memAddr;
    logic [DATA_WIDTH-1:0] r_memData;
    logic                  r_memW;
    logic                  r_memR;
    logic                  r_grantData;
    logic                  r_ifAck;
    logic                  r_dAck;
    logic [DATA_WIDTH-1:0] r_ifRdata;
    logic [DATA_WIDTH-1:0] r_dRdata;
    logic                  r_busy;
    logic                  w_anyReq;
    logic                  w_grantData;

`ifdef MEM_ARB_RR_EN
    // 1 = the last grant went to the data port; on a tie the other requester wins.
    logic                  r_lastData;

    assign w_grantData = d_req && (!if_req || !r_lastData);
`else
    assign w_grantData = d_req;
`endif

    assign w_anyReq = d_req || if_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_memAddr   <= '0;
            r_memData   <= '0;
            r_memW      <= 1'b0;
            r_memR      <= 1'b0;
            r_grantData <= 1'b0;
            r_ifAck     <= 1'b0;
            r_dAck      <= 1'b0;
            r_ifRdata   <= '0;
            r_dRdata    <= '0;
            r_busy      <= 1'b0;
`ifdef MEM_ARB_RR_EN
            r_lastData  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_state     <= ACCESS;
                        r_busy      <= 1'b1;
                        r_grantData <= w_grantData;
                        r_memAddr   <= w_grantData ? d_addr : if_addr;
                        r_memData   <= w_grantData ? d_wdata : '0;
                        r_memW      <= w_grantData && d_we;
                        r_memR      <= !(w_grantData && d_we);
`ifdef MEM_ARB_RR_EN
                        r_lastData  <= w_grantData;
`endif
                    end
                end
                ACCESS: begin
                    if (r_memW) begin
                        // The write commits at this edge; the load result register is left alone.
                        r_state   <= ACK;
                        r_memAddr <= '0;
                        r_memData <= '0;
                        r_memW    <= 1'b0;
                        r_memR    <= 1'b0;
                        r_dAck    <= r_grantData;
                        r_ifAck   <= !r_grantData;
                    end else begin
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    // mem_q settled at the falling edge inside this cycle.
                    if (r_grantData) begin
                        r_dRdata <= mem_q;
                    end else begin
                        r_ifRdata <= mem_q;
                    end
                    r_state   <= ACK;
                    r_memAddr <= '0;
                    r_memData <= '0;
                    r_memW    <= 1'b0;
                    r_memR    <= 1'b0;
                    r_dAck    <= r_grantData;
                    r_ifAck   <= !r_grantData;
                end
                ACK: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_dAck  <= 1'b0;
                    r_ifAck <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr = r_memAddr;
    assign mem_data = r_memData;
    assign mem_w    = r_memW;
    assign mem_r    = r_memR;
    assign if_ack   = r_ifAck;
    assign d_ack    = r_dAck;
    assign if_rdata = r_ifRdata;
    assign d_rdata  = r_dRdata;
    assign busy     = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a behavioural memory, a shadow reference memory and
// an access-level model of grant order and ack latency.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        ifReq;
    logic [15:0] ifAddr;
    logic        ifAck;
    logic [15:0] ifRdata;
    logic        dReq;
    logic        dWe;
    logic [15:0] dAddr;
    logic [15:0] dWdata;
    logic        dAck;
    logic [15:0] dRdata;
    logic [15:0] memAddr;
    logic [15:0] memData;
    logic        memW;
    logic        memR;
    logic [15:0] memQ;
    logic        busy;

    int          vectors = 0;
    int          miscompares = 0;

    logic [15:0] physMem [0:65535];
    logic [15:0] refMem  [0:65535];
    logic [15:0] memRdAddr;
    bit          memInit = 1'b0;
    logic [15:0] expIfRdata;
    logic [15:0] expDRdata;
    bit          lastData;

    mem_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (ifReq),
        .if_addr  (ifAddr),
        .if_ack   (ifAck),
        .if_rdata (ifRdata),
        .d_req    (dReq),
        .d_we     (dWe),
        .d_addr   (dAddr),
        .d_wdata  (dWdata),
        .d_ack    (dAck),
        .d_rdata  (dRdata),
        .mem_addr (memAddr),
        .mem_data (memData),
        .mem_w    (memW),
        .mem_r    (memR),
        .mem_q    (memQ),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] seedWord(input logic [15:0] a);
        logic [15:0] w;
        w = a * 16'h9E37;
        return (a == 16'h0010) ? 16'hBEEF : (w ^ 16'h5A5A);
    endfunction

    // Single-port memory: write and read address sampled on the rising edge, q updated on the falling edge.
    always @(posedge clk) begin
        if (!memInit) begin
            for (int i = 0; i < 65536; i++) physMem[i] <= seedWord(16'(i));
            memInit <= 1'b1;
        end else if (memW) begin
            physMem[memAddr] <= memData;
        end
        memRdAddr <= memAddr;
    end

    always @(negedge clk) memQ <= physMem[memRdAddr];

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Tie-break rule: data first, or under round-robin the requester not served last.
    function automatic bit pickData(input bit d, input bit f);
        if (d && f) begin
`ifdef MEM_ARB_RR_EN
            return !lastData;
`else
            return 1'b1;
`endif
        end
        return d;
    endfunction

    task automatic noteGrant(input bit isData);
        lastData = isData;
    endtask

    task automatic applyStimulus(input bit isData, input bit we, input logic [15:0] addr, input logic [15:0] wdata);
        @(posedge clk);
        #1;
        if (isData) begin
            dReq = 1'b1; dWe = we; dAddr = addr; dWdata = wdata;
        end else begin
            ifReq = 1'b1; ifAddr = addr;
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_if_ack"}, 32'(ifAck), 32'd0);
        checkOutput({tag, "_d_ack"}, 32'(dAck), 32'd0);
        checkOutput({tag, "_mem_w"}, 32'(memW), 32'd0);
        checkOutput({tag, "_mem_r"}, 32'(memR), 32'd0);
        checkOutput({tag, "_mem_addr"}, 32'(memAddr), 32'd0);
        checkOutput({tag, "_mem_data"}, 32'(memData), 32'd0);
        checkOutput({tag, "_if_rdata"}, 32'(ifRdata), 32'd0);
        checkOutput({tag, "_d_rdata"}, 32'(dRdata), 32'd0);
    endtask

    task automatic runAccess(input bit isData, input bit we, input logic [15:0] addr, input logic [15:0] wdata);
        bit          isRead;
        int          expLat;
        int          n;
        int          ackAt;
        int          rCnt;
        int          wCnt;
        int          otherAcks;
        logic [15:0] addrSeen;
        logic        busySeen;
        isRead = !(isData && we);
        expLat = isRead ? 3 : 2;
        n = 0; ackAt = -1; rCnt = 0; wCnt = 0; otherAcks = 0;
        addrSeen = '0; busySeen = 1'b0;
        applyStimulus(isData, we, addr, wdata);
        noteGrant(isData);
        if (!isRead) refMem[addr] = wdata;
        else if (isData) expDRdata = refMem[addr];
        else expIfRdata = refMem[addr];
        while (ackAt < 0 && n < 20) begin
            @(negedge clk);
            rCnt += int'(memR);
            wCnt += int'(memW);
            if (n == 1) begin
                addrSeen = memAddr;
                busySeen = busy;
            end
            if (isData ? dAck : ifAck) ackAt = n;
            if (isData ? ifAck : dAck) otherAcks++;
            n++;
        end
        checkOutput(isData ? "d_latency" : "if_latency", 32'(ackAt), 32'(expLat));
        checkOutput("mem_r_cycles", 32'(rCnt), isRead ? 32'd2 : 32'd0);
        checkOutput("mem_w_cycles", 32'(wCnt), isRead ? 32'd0 : 32'd1);
        checkOutput("mem_addr_in_access", 32'(addrSeen), 32'(addr));
        checkOutput("busy_in_access", 32'(busySeen), 32'd1);
        checkOutput("other_ack", 32'(otherAcks), 32'd0);
        checkOutput("d_rdata", 32'(dRdata), 32'(expDRdata));
        checkOutput("if_rdata", 32'(ifRdata), 32'(expIfRdata));
        if (isData) dReq = 1'b0;
        else ifReq = 1'b0;
    endtask

    task automatic runPair(input logic [15:0] dA, input logic [15:0] fA);
        bit          dataFirst;
        int          dAt;
        int          fAt;
        int          n;
        logic [15:0] dGot;
        logic [15:0] fGot;
        dataFirst = pickData(1'b1, 1'b1);
        noteGrant(dataFirst);
        noteGrant(!dataFirst);
        expDRdata = refMem[dA];
        expIfRdata = refMem[fA];
        dAt = -1; fAt = -1; n = 0; dGot = '0; fGot = '0;
        @(posedge clk);
        #1;
        dReq = 1'b1; dWe = 1'b0; dAddr = dA;
        ifReq = 1'b1; ifAddr = fA;
        while ((dAt < 0 || fAt < 0) && n < 30) begin
            @(negedge clk);
            if (dAck) begin dAt = n; dGot = dRdata; dReq = 1'b0; end
            if (ifAck) begin fAt = n; fGot = ifRdata; ifReq = 1'b0; end
            n++;
        end
        dReq = 1'b0;
        ifReq = 1'b0;
        checkOutput("pair_d_ack_cycle", 32'(dAt), dataFirst ? 32'd3 : 32'd7);
        checkOutput("pair_if_ack_cycle", 32'(fAt), dataFirst ? 32'd7 : 32'd3);
        checkOutput("pair_d_rdata", 32'(dGot), 32'(expDRdata));
        checkOutput("pair_if_rdata", 32'(fGot), 32'(expIfRdata));
    endtask

    task automatic runHeld(input logic [15:0] dA, input logic [15:0] fA);
        int dAcks;
        int fAcks;
        int expD;
        int expF;
        bit isD;
        dAcks = 0; fAcks = 0; expD = 0; expF = 0;
        // Each read occupies four cycles; three complete inside a twelve-cycle window.
        for (int t = 0; t + 3 < 12; t += 4) begin
            isD = pickData(1'b1, 1'b1);
            noteGrant(isD);
            if (isD) expD++;
            else expF++;
        end
        @(posedge clk);
        #1;
        dReq = 1'b1; dWe = 1'b0; dAddr = dA;
        ifReq = 1'b1; ifAddr = fA;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            dAcks += int'(dAck);
            fAcks += int'(ifAck);
        end
        @(posedge clk);
        #1;
        dReq = 1'b0;
        ifReq = 1'b0;
        if (expD > 0) expDRdata = refMem[dA];
        if (expF > 0) expIfRdata = refMem[fA];
        checkOutput("held_d_acks", 32'(dAcks), 32'(expD));
        checkOutput("held_if_acks", 32'(fAcks), 32'(expF));
        @(negedge clk);
        checkOutput("held_d_rdata", 32'(dRdata), 32'(expDRdata));
        checkOutput("held_if_rdata", 32'(ifRdata), 32'(expIfRdata));
    endtask

    initial begin
        logic [15:0] rAddr;
        logic [15:0] rData;
        bit          rIsData;
        bit          rWe;

        reset = 1'b1; ifReq = 1'b0; ifAddr = '0;
        dReq = 1'b0; dWe = 1'b0; dAddr = '0; dWdata = '0;
        for (int i = 0; i < 65536; i++) refMem[i] = seedWord(16'(i));
        expIfRdata = '0; expDRdata = '0; lastData = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        runAccess(1'b0, 1'b0, 16'h0010, 16'h0000);
        checkOutput("fetch_beef", 32'(ifRdata), 32'h0000BEEF);
        @(negedge clk);
        checkOutput("busy_after_fetch", 32'(busy), 32'd0);

        runAccess(1'b1, 1'b1, 16'h0200, 16'h1234);
        runAccess(1'b1, 1'b0, 16'h0200, 16'h0000);
        checkOutput("load_1234", 32'(dRdata), 32'h00001234);
        checkOutput("fetch_unchanged", 32'(ifRdata), 32'h0000BEEF);

        for (int k = 0; k < 16; k++) begin
            rIsData = 1'($urandom_range(0, 1));
            rWe = rIsData ? 1'($urandom_range(0, 1)) : 1'b0;
            rAddr = 16'h0300 + 16'($urandom_range(0, 15));
            rData = 16'($urandom);
            runAccess(rIsData, rWe, rAddr, rData);
        end

        runPair(16'h0004, 16'h0300 + 16'($urandom_range(0, 15)));
        runPair(16'h0004, 16'h0040);

        runHeld(16'h0304, 16'h0010);

        // Reset while a write sits in ACCESS: the memory still commits it, the ack is lost.
        rAddr = 16'h0500 + 16'($urandom_range(0, 255));
        rData = 16'($urandom);
        applyStimulus(1'b1, 1'b1, rAddr, rData);
        @(negedge clk);
        checkOutput("rst_idle_no_ack", 32'(dAck), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        dReq = 1'b0;
        @(negedge clk);
        checkOutput("rst_access_mem_w", 32'(memW), 32'd1);
        @(posedge clk);
        #1;
        refMem[rAddr] = rData;
        expIfRdata = '0;
        expDRdata = '0;
        lastData = 1'b0;
        @(negedge clk);
        checkAllZero("after_reset");
        checkOutput("rst_write_committed", 32'(physMem[rAddr]), 32'(rData));
        @(posedge clk);
        #1;
        reset = 1'b0;
        runAccess(1'b0, 1'b0, rAddr, 16'h0000);
        checkOutput("fetch_after_reset", 32'(ifRdata), 32'(rData));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
